fuzz_txn_tracker: RTL and testbench

- Sits directly downstream of the IP under fuzz (AES-128 path), beside the random fuzzer. Taps the muxed start/input stream and the IP's out_valid/out data.
- Keeps an in-order FIFO of in-flight transactions and pairs each IP output with the input that caused it. Emits one record per completed transaction, carrying the measured latency.
- Raises sticky alarms for hang, spurious output and overflow. These feed error capture and coverage logic.

---
 rtl/fuzz_txn_tracker.sv | 160 ++++++++++++++++
 tb/tb_fuzz_txn_tracker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_txn_tracker.sv
// In-order transaction tracker for a fuzzed IP: pairs each IP output with the input
// that caused it, reports latency, and raises sticky hang/spurious/overflow alarms.
module fuzz_txn_tracker #(
  parameter int INPUT_WIDTH    = 256,
  parameter int OUTPUT_WIDTH   = 128,
  parameter int DEPTH          = 4,
  parameter int WATCHDOG_LIMIT = 1000,
  parameter int LAT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ip_start,
  input  logic [INPUT_WIDTH-1:0]   ip_input,
  input  logic                     ip_out_valid,
  input  logic [OUTPUT_WIDTH-1:0]  ip_out_data,
  input  logic                     clear,
  output logic                     rec_valid,
  output logic [INPUT_WIDTH-1:0]   rec_input,
  output logic [OUTPUT_WIDTH-1:0]  rec_output,
  output logic [LAT_W-1:0]         rec_latency,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [31:0]              txn_count,
  output logic                     alarm_hang,
  output logic                     alarm_spurious,
  output logic                     alarm_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [LAT_W-1:0] LIMIT = LAT_W'(WATCHDOG_LIMIT);

  typedef enum logic {ST_RUN, ST_HANG} state_e;

  typedef struct packed {
    logic [INPUT_WIDTH-1:0] data;
    logic [LAT_W-1:0]       ts;
  } entry_t;

  entry_t                  mem_q [DEPTH];
  entry_t                  head;
  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [LAT_W-1:0]        ts_q, ts_d, age;
  logic                    rec_valid_q, rec_valid_d;
  logic [INPUT_WIDTH-1:0]  rec_input_q, rec_input_d;
  logic [OUTPUT_WIDTH-1:0] rec_output_q, rec_output_d;
  logic [LAT_W-1:0]        rec_latency_q, rec_latency_d;
  logic [31:0]             txn_q, txn_d;
  logic                    hang_q, hang_d, spur_q, spur_d, ovf_q, ovf_d;
  logic                    empty, full, do_pop, do_push, start_ok;
  logic                    spurious, overflow, hang_hit;

  // NOTE: every always_comb target is given a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    ts_d          = ts_q + LAT_W'(1);
    rec_valid_d   = 1'b0;
    rec_input_d   = rec_input_q;
    rec_output_d  = rec_output_q;
    rec_latency_d = rec_latency_q;
    txn_d         = txn_q;

    head     = mem_q[rd_ptr_q];
    age      = ts_q - head.ts;
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = !clear && ip_out_valid && !empty;
    spurious = !clear && ip_out_valid && empty;
    start_ok = !clear && ip_start && (state_q == ST_RUN);
    // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
    do_push  = start_ok && (!full || do_pop);
    overflow = start_ok && full && !do_pop;
    hang_hit = !clear && (state_q == ST_RUN) && !empty && (age > LIMIT);

    if (do_pop) begin
      rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      rec_valid_d   = 1'b1;
      rec_input_d   = head.data;
      rec_output_d  = ip_out_data;
      rec_latency_d = (state_q == ST_HANG) ? '1 : age;
      txn_d         = txn_q + 32'd1;
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (hang_hit) begin
      state_d = ST_HANG;
    end

    hang_d = hang_q | hang_hit;
    spur_d = spur_q | spurious;
    ovf_d  = ovf_q | overflow;

    if (clear) begin
      state_d  = ST_RUN;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      hang_d   = 1'b0;
      spur_d   = 1'b0;
      ovf_d    = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      ts_q          <= '0;
      rec_valid_q   <= 1'b0;
      rec_input_q   <= '0;
      rec_output_q  <= '0;
      rec_latency_q <= '0;
      txn_q         <= '0;
      hang_q        <= 1'b0;
      spur_q        <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      ts_q          <= ts_d;
      rec_valid_q   <= rec_valid_d;
      rec_input_q   <= rec_input_d;
      rec_output_q  <= rec_output_d;
      rec_latency_q <= rec_latency_d;
      txn_q         <= txn_d;
      hang_q        <= hang_d;
      spur_q        <= spur_d;
      ovf_q         <= ovf_d;
    end
  end

  // NOTE: entry storage is not reset; occupancy gates every read, so stale slots are never used.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= '{data: ip_input, ts: ts_q};
    end
  end

  assign rec_valid      = rec_valid_q;
  assign rec_input      = rec_input_q;
  assign rec_output     = rec_output_q;
  assign rec_latency    = rec_latency_q;
  assign inflight       = count_q;
  assign txn_count      = txn_q;
  assign alarm_hang     = hang_q;
  assign alarm_spurious = spur_q;
  assign alarm_overflow = ovf_q;

endmodule

// File: tb/tb_fuzz_txn_tracker.sv
// Self-checking bench for fuzz_txn_tracker: vector table, directed corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_fuzz_txn_tracker;

  localparam int IW = 256;
  localparam int OW = 128;
  localparam int DEPTH = 4;
  localparam int LIMIT = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ip_start = 1'b0;
  logic [IW-1:0] ip_input = '0;
  logic          ip_out_valid = 1'b0;
  logic [OW-1:0] ip_out_data = '0;
  logic          clear = 1'b0;
  logic          rec_valid;
  logic [IW-1:0] rec_input;
  logic [OW-1:0] rec_output;
  logic [15:0]   rec_latency;
  logic [2:0]    inflight;
  logic [31:0]   txn_count;
  logic          alarm_hang, alarm_spurious, alarm_overflow;

  fuzz_txn_tracker #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DEPTH(DEPTH),
    .WATCHDOG_LIMIT(LIMIT), .LAT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ip_start(ip_start), .ip_input(ip_input),
    .ip_out_valid(ip_out_valid), .ip_out_data(ip_out_data), .clear(clear),
    .rec_valid(rec_valid), .rec_input(rec_input), .rec_output(rec_output),
    .rec_latency(rec_latency), .inflight(inflight), .txn_count(txn_count),
    .alarm_hang(alarm_hang), .alarm_spurious(alarm_spurious),
    .alarm_overflow(alarm_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute cycle numbers and a queue of pending inputs.
  typedef struct {
    logic [IW-1:0] d;
    int unsigned   t;
  } ment_t;

  ment_t       mq[$];
  int unsigned now;
  bit          m_hung;
  bit          e_rv, e_hang, e_spur, e_ovf;
  logic [IW-1:0] e_rin;
  logic [OW-1:0] e_rout;
  logic [15:0]   e_lat;
  logic [31:0]   e_txn;

  task automatic model_reset();
    mq.delete();
    now = 0; m_hung = 0;
    e_rv = 0; e_hang = 0; e_spur = 0; e_ovf = 0;
    e_rin = '0; e_rout = '0; e_lat = '0; e_txn = '0;
  endtask

  task automatic model_step(input bit s, input logic [IW-1:0] d, input bit v,
                            input logic [OW-1:0] o, input bit c);
    bit    hang_now;
    ment_t e;
    e_rv = 0;
    if (c) begin
      mq.delete();
      m_hung = 0; e_hang = 0; e_spur = 0; e_ovf = 0;
    end else begin
      hang_now = !m_hung && mq.size() > 0 && (now - mq[0].t) > LIMIT;
      if (v) begin
        if (mq.size() == 0) e_spur = 1;
        else begin
          e = mq.pop_front();
          e_rv = 1; e_rin = e.d; e_rout = o;
          e_lat = m_hung ? 16'hFFFF : 16'(now - e.t);
          e_txn = e_txn + 1;
        end
      end
      if (s && !m_hung) begin
        if (mq.size() < DEPTH) mq.push_back('{d: d, t: now});
        else e_ovf = 1;
      end
      if (hang_now) begin
        m_hung = 1; e_hang = 1;
      end
    end
    now++;
  endtask

  task automatic compare_all();
    check("rec_valid", rec_valid, e_rv);
    if (e_rv) begin
      check("rec_input", rec_input, e_rin);
      check("rec_output", rec_output, e_rout);
      check("rec_latency", rec_latency, e_lat);
    end
    check("inflight", inflight, mq.size());
    check("txn_count", txn_count, e_txn);
    check("alarm_hang", alarm_hang, e_hang);
    check("alarm_spurious", alarm_spurious, e_spur);
    check("alarm_overflow", alarm_overflow, e_ovf);
  endtask

  task automatic cycle(input bit s, input logic [IW-1:0] d, input bit v,
                       input logic [OW-1:0] o, input bit c);
    ip_start = s; ip_input = d; ip_out_valid = v; ip_out_data = o; clear = c;
    @(posedge clk);
    model_step(s, d, v, o, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, '0, 0);
  endtask

  // Vector table: one row per clock, expected outputs hand-derived.
  typedef struct {
    bit s; logic [7:0] ib; bit v; logic [7:0] ob; bit c;
    bit rv; logic [15:0] lat; int inf; bit ovf; bit spur;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit s, input logic [7:0] ib, input bit v, input logic [7:0] ob,
                     input bit c, input bit rv, input logic [15:0] lat, input int inf,
                     input bit ovf, input bit spur);
    tbl.push_back('{s: s, ib: ib, v: v, ob: ob, c: c, rv: rv, lat: lat, inf: inf, ovf: ovf, spur: spur});
  endtask

  logic [31:0] txn_saved;

  initial begin
    model_reset();
    #20;
    check("reset_rec_valid", rec_valid, 0);
    check("reset_inflight", inflight, 0);
    check("reset_txn", txn_count, 0);
    check("reset_alarms", {alarm_hang, alarm_spurious, alarm_overflow}, 0);
    check("reset_rec_latency", rec_latency, 0);
    #2 rst_n = 1'b1;

    // Single transaction, latency 11.
    idle(10);
    cycle(1, {32{8'hA5}}, 0, '0, 0);
    idle(10);
    cycle(0, '0, 1, {8'h3A, 8'hD7, {13{8'h00}}, 8'h01}, 0);
    check("single_rv", rec_valid, 1);
    check("single_lat", rec_latency, 11);
    check("single_in", rec_input, {32{8'hA5}});
    check("single_out", rec_output, {8'h3A, 8'hD7, {13{8'h00}}, 8'h01});
    check("single_txn", txn_count, 1);
    check("single_inf", inflight, 0);

    // Burst, overflow, clear, full push+pop, spurious cases.
    for (int i = 0; i < 4; i++) add(1, 8'(8'h10 + i), 0, 0, 0, 0, 0, i + 1, 0, 0);
    add(1, 8'h15, 0, 0, 0, 0, 0, 4, 1, 0);
    for (int i = 5; i < 11; i++) add(0, 0, 0, 0, 0, 0, 0, 4, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'(8'hB0 + i), 0, 1, 11, 3 - i, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 8'(8'h20 + i), 0, 0, 0, 0, 0, i + 1, 0, 0);
    add(1, 8'h24, 1, 8'hC0, 0, 1, 4, 4, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'(8'hC1 + i), 0, 1, 4, 3 - i, 0, 0);
    add(0, 0, 1, 8'hD0, 0, 0, 0, 0, 0, 1);
    add(1, 8'h30, 1, 8'hD1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 8'hD2, 0, 1, 1, 0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].s, {32{tbl[i].ib}}, tbl[i].v, {16{tbl[i].ob}}, tbl[i].c);
      check($sformatf("tbl%0d_rv", i), rec_valid, tbl[i].rv);
      if (tbl[i].rv) check($sformatf("tbl%0d_lat", i), rec_latency, tbl[i].lat);
      check($sformatf("tbl%0d_inf", i), inflight, tbl[i].inf);
      check($sformatf("tbl%0d_ovf", i), alarm_overflow, tbl[i].ovf);
      check($sformatf("tbl%0d_spur", i), alarm_spurious, tbl[i].spur);
    end

    // Watchdog boundary: age exactly LIMIT is legal.
    cycle(0, '0, 0, '0, 1);
    cycle(1, {32{8'h41}}, 0, '0, 0);
    idle(19);
    cycle(0, '0, 1, {16{8'h42}}, 0);
    check("wd_edge_rv", rec_valid, 1);
    check("wd_edge_lat", rec_latency, 20);
    check("wd_edge_hang", alarm_hang, 0);

    // Hang: alarm after age 21, starts ignored, saturated latency.
    cycle(1, {32{8'h51}}, 0, '0, 0);
    idle(20);
    check("hang_pre", alarm_hang, 0);
    idle(1);
    check("hang_set", alarm_hang, 1);
    cycle(1, {32{8'h52}}, 0, '0, 0);
    check("hang_start_ign", inflight, 1);
    check("hang_no_ovf", alarm_overflow, 0);
    idle(2);
    cycle(0, '0, 1, {16{8'h53}}, 0);
    check("hang_rv", rec_valid, 1);
    check("hang_lat_sat", rec_latency, 16'hFFFF);
    check("hang_in", rec_input, {32{8'h51}});

    // Overflow then hang, then clear restores normal operation.
    cycle(0, '0, 0, '0, 1);
    for (int i = 0; i < 5; i++) cycle(1, {32{8'(8'h60 + i)}}, 0, '0, 0);
    idle(17);
    check("ovh_hang", alarm_hang, 1);
    check("ovh_ovf", alarm_overflow, 1);
    txn_saved = e_txn;
    cycle(0, '0, 0, '0, 1);
    check("clr_alarms", {alarm_hang, alarm_spurious, alarm_overflow}, 0);
    check("clr_inf", inflight, 0);
    cycle(1, {32{8'h70}}, 0, '0, 0);
    idle(4);
    cycle(0, '0, 1, {16{8'h71}}, 0);
    check("clr_lat", rec_latency, 5);
    check("clr_txn", txn_count, txn_saved + 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 40, {8{$urandom()}}, $urandom_range(0, 99) < 35,
            {4{$urandom()}}, $urandom_range(0, 99) < 2);
    end

    // Asynchronous reset with two entries in flight.
    cycle(0, '0, 0, '0, 1);
    cycle(1, {32{8'h81}}, 0, '0, 0);
    cycle(1, {32{8'h82}}, 0, '0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_inf", inflight, 0);
    check("arst_txn", txn_count, 0);
    check("arst_rv", rec_valid, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle(0, '0, 1, {16{8'h83}}, 0);
    check("arst_spur", alarm_spurious, 1);
    check("arst_no_rec", rec_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
